// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble, one shift per clock)
module bcd2bin_seq #(
   parameter int DIGITS = 4,
   parameter int W      = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic [W-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int          DW      = 4 * DIGITS;
   localparam int          CW      = $clog2(W + 1);
   localparam logic [63:0] MAX_DEC = 64'(10 ** DIGITS) - 64'd1;

   if ((64'd1 << W) <= MAX_DEC) begin : g_width_check
      $error("bcd2bin_seq: W too small to hold the largest DIGITS-digit decimal value");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   d_q, d_d;
   logic [W-1:0]    r_q, r_d;
   logic [CW-1:0]   c_q, c_d;
   logic [W-1:0]    bin_q, bin_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic [DW-1:0]   d_sh;
   logic [W-1:0]    r_sh;
   logic            bad_digit;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end

      // Shift {D,R} right, then pull each digit that reached 8..15 back by 3
      d_sh = {1'b0, d_q[DW-1:1]};
      r_sh = {d_q[0], r_q[W-1:1]};
      for (int i = 0; i < DIGITS; i++) begin
         if (d_sh[4*i +: 4] >= 4'd8) d_sh[4*i +: 4] = d_sh[4*i +: 4] - 4'd3;
      end

      state_d = state_q;
      d_d     = d_q;
      r_d     = r_q;
      c_d     = c_q;
      bin_d   = bin_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               d_d = bcd;
               r_d = '0;
               if (bad_digit) begin
                  err_d   = 1'b1;
                  bin_d   = '0;
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  err_d   = 1'b0;
                  c_d     = CW'(W);
                  busy_d  = 1'b1;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            d_d = d_sh;
            r_d = r_sh;
            c_d = c_q - CW'(1);
            if (c_q == CW'(1)) begin
               bin_d   = r_sh;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = FINISH;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         d_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         bin_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         r_q     <= r_d;
         c_q     <= c_d;
         bin_q   <= bin_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bin  = bin_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: doc/bcd2bin_seq.md
# bcd2bin_seq

Sequential BCD-to-binary converter: the inverse of the board's combinational binary-to-BCD path. It takes a packed decimal value, for example one keyed in digit-by-digit from the debounced buttons, and produces the unsigned binary value. The conversion uses reverse double-dabble: one shift per clock, with a start/busy/done handshake. It sits between the button-entry logic and the binary counter/arithmetic that feeds the 7-segment display path.

## Interface
- DIGITS, 4: number of BCD digits in `bcd`.
- W, 14: result width.
  - Must satisfy 2^W > 10^DIGITS − 1; this is checked by an elaboration-time assertion.
  - Defaults: 9999 < 16384.
- clk  in  1: system clock; all state is updated on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request a conversion; sampled only in IDLE.
- bcd  in  4*DIGITS: packed BCD, digit 0 in bits [3:0]; sampled on the accepted `start` edge only.
- bin  out  W: binary result; registered, held until the next accepted `start`.
- busy  out  1: high from the accepting edge until the conversion completes.
- done  out  1: one-cycle pulse; `bin` and `err` are valid while it is high.
- err  out  1: high with `done` if any input digit was > 9; held with `bin`.

## Operation
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - `busy`=0.
  - On `start`=1, capture `bcd` into digit register D (4*DIGITS bits) and clear result register R (W bits).
  - Check every digit. If any digit > 9, set `err`=1, set R=0, and go to FINISH with no shifting. Otherwise set `err`=0, load shift count C=W and go to SHIFT.
  - `busy` rises on the accepting edge.
- SHIFT, once per clock:
  - Shift the concatenation {D,R} right by 1 bit: the D LSB enters the R MSB, and the D MSB receives 0.
  - Then, for each 4-bit digit of the shifted D with value ≥ 8, subtract 3.
  - Decrement C. On the edge where C goes 1→0, go to FINISH.
- FINISH:
  - `bin` ← R, `done`=1 for exactly this cycle, `busy`=0.
  - Return to IDLE on the next edge.
  - A `start` that is high during FINISH is ignored.
- After exactly W shifts, R holds the binary value. Shifts beyond the significant bits move only zeros, so any W satisfying the constraint gives an exact result.
- `start` while `busy`=1 is ignored and not queued. `bcd` changes during a conversion have no effect.
- Width rules:
  - Each digit correction is a 4-bit subtract. The operand is always in 8..15, so there is no borrow.
  - R never overflows under the W constraint.
- `bin`/`err` update only at FINISH or on an `err` capture. Otherwise they hold their last values.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state=IDLE, `bin`=0, `busy`=0, `done`=0, `err`=0, D=0, R=0, C=0.
- Reset asserted mid-conversion aborts immediately. No `done` is produced, and the bench must see all outputs at their reset values without waiting for a clock edge.
- Valid input, `start` accepted at edge 0:
  - `busy`=1 after edge 0.
  - Shifts occur on edges 1..W.
  - FINISH is entered at edge W: `busy`=0 and `done`=1 with `bin` valid in the cycle after edge W.
  - Latency from the accepting edge to the `done` cycle is W edges (14 by default).
- Invalid input, `start` accepted at edge 0: FINISH is entered at edge 0, so `done`=1, `err`=1, `bin`=0 in the cycle after edge 0.
- Throughput: the earliest next acceptance is the edge that leaves FINISH+1. `start` held high continuously therefore gives one conversion every W+2 cycles.
- `done` is never high for two consecutive cycles.

## Test plan
- Reset, then `bcd`=16'h0000, one-cycle `start` → `busy` high for 14 cycles, `done` pulse, `bin`=0, `err`=0; `done` exactly 14 edges after acceptance.
- `bcd`=16'h9999 → `bin`=14'd9999 (0x270F), `err`=0. Then `bcd`=16'h1234 → `bin`=1234. Then 16'h0007 → 7.
- `bcd`=16'h12A4 → `done` one cycle after acceptance, `err`=1, `bin`=0. Then a valid 16'h0042 → `err` cleared, `bin`=42.
- Start 16'h0500, pulse `start` again with 16'h0001 at shift cycle 5 → ignored; single `done` with `bin`=500.
- Start 16'h4321, deassert `rst_n` between edges at shift cycle 7 → outputs go to 0 asynchronously with no `done`. Release `rst_n` and convert 16'h0010 → `bin`=10.
- `start` held high for 3 conversions with 16'h0001 → 3 `done` pulses spaced 16 cycles apart, each with `bin`=1. Then a random sweep of all valid 4-digit values checked against a reference model.
